// File: rtl/wisc_fetch_unit.sv
// WISC-S15 fetch stage: PC generation, up to two outstanding imem requests, 2-entry prefetch queue.
// Request to decode-visible latency is grant + k + 1; a full queue or pending responses stall issue.

module wisc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

module wisc_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               dec_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic [ADDR_W-1:0]  fetch_pc
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } q_ent_t;

  q_ent_t              q_push_dat;
  q_ent_t              q_head;
  logic [1:0]          count;
  logic [1:0]          outst;
  logic [2:0]          drop;
  logic [ADDR_W-1:0]   ifl_head;
  logic                gnt_fire;
  logic                rsp_keep;
  logic                rsp_drop;

  // Issue only when every outstanding response is guaranteed a queue slot.
  assign imem_req  = !rst && !halt && !redirect_valid &&
                     (({1'b0, count} + {1'b0, outst}) < 3'd2);
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;
  assign rsp_drop  = imem_rvalid && (drop != 3'd0);
  assign rsp_keep  = imem_rvalid && (drop == 3'd0) && (outst != 2'd0);

  assign q_push_dat  = '{instr: imem_rdata, pc: ifl_head};
  assign instr_valid = (count != 2'd0);
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;

  wisc_fifo #(.W(ADDR_W), .DEPTH(2)) u_inflight (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (gnt_fire),
    .push_dat (fetch_pc),
    .pop      (rsp_keep),
    .pop_dat  (ifl_head),
    .count    (outst)
  );

  wisc_fifo #(.W($bits(q_ent_t)), .DEPTH(2)) u_prefetch (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_dat (q_push_dat),
    .pop      (instr_valid && dec_ready),
    .pop_dat  (q_head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (gnt_fire) begin
      fetch_pc <= fetch_pc + 1'b1;
    end
  end

  // Redirect adds to any drops still pending so back-to-back redirects stay correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 3'd0;
    end else if (redirect_valid) begin
      drop <= drop + {1'b0, outst} - {2'b00, rsp_keep || rsp_drop};
    end else if (rsp_drop) begin
      drop <= drop - 3'd1;
    end
  end

  a_rvalid_proto: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outst == 2'd0) && (drop == 3'd0)));
endmodule
